mem_arbiter: RTL

Sequential arbiter that lets the mRisc instruction-fetch stage and data-memory stage share the single-port `memoria` (16-bit address, 16-bit data, one write enable). It sits between the two mRisc memory requesters and the memory. It grants one access at a time through a two-phase req/ack handshake, and optionally guards the fetch port against starvation.

---
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus between the mRisc fetch/data requesters, the memory
// and mem_arbiter. The arbiter uses the slave modport. The requesters and the
// memory together use the master modport.
interface mem_arbiter_if;
  logic        ReqI;
  logic [15:0] EndI;
  logic        AckI;
  logic [15:0] DadoI;
  logic        ReqD;
  logic        EscD;
  logic [15:0] EndD;
  logic [15:0] ValorEscD;
  logic        AckD;
  logic [15:0] DadoD;
  logic [15:0] EndMem;
  logic [15:0] ValorEscrito;
  logic        EscMem;
  logic [15:0] ValorLido;

  modport slave (
    input  ReqI, EndI, ReqD, EscD, EndD, ValorEscD, ValorLido,
    output AckI, DadoI, AckD, DadoD, EndMem, ValorEscrito, EscMem
  );

  modport master (
    output ReqI, EndI, ReqD, EscD, EndD, ValorEscD, ValorLido,
    input  AckI, DadoI, AckD, DadoD, EndMem, ValorEscrito, EscMem
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port memoria between the mRisc fetch and
// data stages. It grants one access at a time. Every access is 2 cycles
// (BUSY then RESP), and each access ends with a one-cycle Ack.
// Optional feature: define ARB_STARVE_GUARD_EN to force a fetch grant after
// MAX_D_STREAK consecutive data grants while ReqI is pending.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 3
) (
  input  logic          CLK,
  input  logic          RESET_N,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t state, state_nx;
  logic   arb;
  logic   grant_i;
  logic   grant_d;
  logic   done_i;
  logic   done_d;
  logic   force_i;

  // state register
  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  // next-state: arbitrate in IDLE/RESP, otherwise finish the access
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, RESP: begin
        if (grant_d)      state_nx = BUSY_D;
        else if (grant_i) state_nx = BUSY_I;
        else              state_nx = IDLE;
      end
      BUSY_I, BUSY_D: state_nx = RESP;
      default:        state_nx = IDLE;
    endcase
  end

  // output decode: grant and completion strobes for the datapath
  always_comb begin
    arb     = (state == IDLE) || (state == RESP);
    grant_d = arb && bus.ReqD && !force_i;
    grant_i = arb && bus.ReqI && (!bus.ReqD || force_i);
    done_i  = (state == BUSY_I);
    done_d  = (state == BUSY_D);
  end

  // registered memory-side and requester-side outputs
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      bus.AckI         <= 1'b0;
      bus.AckD         <= 1'b0;
      bus.DadoI        <= '0;
      bus.DadoD        <= '0;
      bus.EndMem       <= '0;
      bus.ValorEscrito <= '0;
      bus.EscMem       <= 1'b0;
    end else begin
      bus.AckI <= done_i;
      bus.AckD <= done_d;
      if (grant_d) begin
        bus.EndMem       <= bus.EndD;
        bus.ValorEscrito <= bus.ValorEscD;
        bus.EscMem       <= bus.EscD;
      end else if (grant_i) begin
        bus.EndMem <= bus.EndI;
        bus.EscMem <= 1'b0;
      end else begin
        bus.EscMem <= 1'b0;
      end
      if (done_i) bus.DadoI <= bus.ValorLido;
      // During BUSY_D, EscMem still holds the latched write flag.
      if (done_d && !bus.EscMem) bus.DadoD <= bus.ValorLido;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [STREAK_W-1:0] streak;

  // fetch wins once the data streak reaches the limit with ReqI pending
  always_comb begin
    force_i = bus.ReqI && (streak == STREAK_W'(MAX_D_STREAK));
  end

  // count consecutive data grants made while a fetch is waiting
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      streak <= '0;
    end else if (arb) begin
      if (!bus.ReqI || grant_i)
        streak <= '0;
      else if (grant_d && (streak != STREAK_W'(MAX_D_STREAK)))
        streak <= streak + 1'b1;
    end
  end
`else
  logic [STREAK_W-1:0] unused_cfg;
  assign unused_cfg = STREAK_W'(MAX_D_STREAK);

  // strict data priority
  always_comb begin
    force_i = 1'b0;
  end
`endif

endmodule
